pls_byte_bus_bridge: RTL
========================

Name: pls_byte_bus_bridge

Overview:
- Upstream master for the 4-word x 32-bit Avalon on-chip RAM (pls_onchip_memory2_0).
- Converts 8-bit, byte-addressed CPU-side requests (16-byte window) into single 32-bit Avalon-MM accesses with byteenables.
- Handles the RAM's fixed 1-cycle read latency and returns the selected byte to the CPU with a valid pulse.
- Also drives the RAM's clken and reset_req so the memory is frozen during reset.

Parameters:
- ADDR_W, 4, CPU byte-address width; upper ADDR_W-2 bits form the word address.
- DATA_W, 32, Avalon data width; fixed, 4 byte lanes.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; single clock domain
- cpu_req  in  1  request valid; held until accepted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  4  byte address
- cpu_wdata  in  8  write byte
- cpu_ready  out  1  bridge can accept a request this cycle
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid
- cpu_rdata  out  8  read byte
- mem_address  out  2  Avalon word address
- mem_byteenable  out  4  one-hot byte lane
- mem_chipselect  out  1  Avalon chipselect
- mem_write  out  1  Avalon write
- mem_writedata  out  32  write byte replicated on all 4 lanes
- mem_readdata  in  32  RAM read data, valid 1 cycle after address
- mem_clken  out  1  RAM clock enable
- mem_reset_req  out  1  RAM reset_req
- stat_rd_count  out  16  read counter (optional feature)
- stat_wr_count  out  16  write counter (optional feature)

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_reset_req = 1; all other outputs = 0.
  - mem_reset_req and mem_clken change on the first edge with reset_n = 1.
  - cpu_ready = 1 from the cycle after that edge.
- States: IDLE, WR, RD_ADDR, RD_DATA.
- cpu_ready = (state == IDLE) and not mem_reset_req.
- Accept: a request is accepted on an edge where cpu_req and cpu_ready are both 1. At that edge, register:
  - mem_address = cpu_addr[3:2]
  - mem_byteenable = 1 << cpu_addr[1:0]
  - mem_writedata = {4{cpu_wdata}}
  - the byte-lane index, kept for the read mux
  - mem_chipselect = 1
- Write path: IDLE -> WR with mem_write = 1 for exactly one cycle; WR -> IDLE. Busy for 1 cycle; throughput is one write every 2 cycles.
- Read path: IDLE -> RD_ADDR with mem_write = 0; the RAM samples the address at the end of RD_ADDR. RD_ADDR -> RD_DATA with mem_chipselect dropped to 0. At the end of RD_DATA:
  - cpu_rdata <= mem_readdata[8*lane +: 8]
  - cpu_rvalid <= 1 for one cycle
  - state <= IDLE
- Read timing: accepted at edge E0, rvalid is high in the cycle after E0+3 edges total (the cycle following E2). cpu_ready is already 1 in the rvalid cycle, so a new request may be accepted coincident with rvalid.
- mem_chipselect/mem_write are 0 in IDLE; mem_write is never 1 outside WR.
- Sequential consistency: a read to the same word immediately after a write returns the new byte (the write commits at end of WR, the read address is presented one cycle later). The RAM's DONT_CARE read-during-write mode is never exercised.
- cpu_addr, cpu_we and cpu_wdata are ignored when not accepting. A cpu_req drop while ready has no effect.
- Reset mid-operation: any in-flight access is aborted. A pending cpu_rvalid is not generated, and mem_write is forced to 0 on the reset edge. A partially issued write may or may not have committed.
- Address wrap: 4-bit byte address only, no out-of-range case.

Optional Feature:
- Macro: PLS_BRIDGE_STATS_EN.
- Defined:
  - stat_rd_count increments on each cpu_rvalid pulse.
  - stat_wr_count increments on each WR cycle.
  - Both are 16-bit saturating at 16'hFFFF and cleared by reset.
- Undefined: ports remain, tied to 0; no counter flops are synthesized.

Decomposition:
- Package pls_bridge_pkg:
  - state enum (IDLE, WR, RD_ADDR, RD_DATA)
  - constants BYTE_LANES = 4, WORD_ADDR_W = 2
  - function lane_onehot(lane) for byteenable generation.
- Sub-module pls_byte_lane_mux: combinational 32->8 read-lane select and 8->32 replicate. Kept separate so it can be reused by other byte-wide masters on the same RAM.

Test Plan:
- Reset release: hold reset_n = 0 for 4 cycles -> mem_reset_req = 1 and mem_clken = 0 throughout; one edge after release, mem_reset_req = 0 and mem_clken = 1; cpu_ready = 1 in the following cycle.
- Write then read: write 0xA5 to addr 0x6, then read 0x6 -> mem_address = 1 and mem_byteenable = 4'b0100 for one mem_write cycle; rvalid 3 edges after read accept with cpu_rdata = 0xA5.
- Lane isolation: write 0x11, 0x22, 0x33, 0x44 to addrs 0xC..0xF, then read 0xD -> cpu_rdata = 0x22; RAM word 3 = 0x44332211.
- Back-to-back: hold cpu_req = 1 for 8 alternating write/read requests -> cpu_ready deasserts correctly and no request is lost or duplicated; read data matches a scoreboard model.
- Reset mid-read: assert reset_n = 0 in RD_ADDR -> no cpu_rvalid pulse, state IDLE after release, next read returns correct data.
- Stats (PLS_BRIDGE_STATS_EN): 3 writes and 2 reads -> stat_wr_count = 3, stat_rd_count = 2. With the macro undefined, both stay 0.

Source files
------------

// File: rtl/pls_bridge_pkg.sv
// Shared types and helpers for the byte-wide CPU bridge onto the 4 x 32-bit on-chip RAM.
package pls_bridge_pkg;

    localparam int BYTE_LANES  = 4;
    localparam int WORD_ADDR_W = 2;
    localparam int LANE_W      = $clog2(BYTE_LANES);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA
    } state_t;

    function automatic logic [BYTE_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        return BYTE_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/pls_byte_lane_mux.sv
// Byte-lane steering between a 32-bit RAM word and an 8-bit master: read-lane select
// and write-byte replication. Purely combinational so other byte masters can share it.
module pls_byte_lane_mux
    import pls_bridge_pkg::*;
(
    input  logic [8*BYTE_LANES-1:0] i_word,
    input  logic [LANE_W-1:0]       i_lane,
    input  logic [7:0]              i_byte,
    output logic [7:0]              o_byte,
    output logic [8*BYTE_LANES-1:0] o_word
);

    assign o_byte = i_word[8*i_lane +: 8];

    generate
        for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_rep
            assign o_word[8*gi +: 8] = i_byte;
        end
    endgenerate

endmodule

// File: rtl/pls_byte_bus_bridge.sv
// Byte-addressed CPU master onto the 4 x 32-bit Avalon on-chip RAM (1-cycle read latency).
// Optional access counters are enabled with the PLS_BRIDGE_STATS_EN macro.
module pls_byte_bus_bridge
    import pls_bridge_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-3:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    output logic [15:0]       stat_rd_count,
    output logic [15:0]       stat_wr_count
);

    state_t              r_state, w_state_next;
    logic                r_mem_reset_req, r_mem_clken;
    logic                r_cpu_ready, w_cpu_ready;
    logic                r_cpu_rvalid, w_cpu_rvalid;
    logic [7:0]          r_cpu_rdata, w_cpu_rdata;
    logic [ADDR_W-3:0]   r_mem_address, w_mem_address;
    logic [3:0]          r_mem_byteenable, w_mem_byteenable;
    logic                r_mem_chipselect, w_mem_chipselect;
    logic                r_mem_write, w_mem_write;
    logic [DATA_W-1:0]   r_mem_writedata, w_mem_writedata;
    logic [LANE_W-1:0]   r_lane, w_lane;
    logic [7:0]          w_rd_byte;
    logic [DATA_W-1:0]   w_wr_word;
    logic                w_accept;

    pls_byte_lane_mux u_lane_mux (
        .i_word (mem_readdata),
        .i_lane (r_lane),
        .i_byte (cpu_wdata),
        .o_byte (w_rd_byte),
        .o_word (w_wr_word)
    );

    always_comb begin
        w_accept         = cpu_req && r_cpu_ready;
        w_state_next     = r_state;
        w_mem_address    = r_mem_address;
        w_mem_byteenable = r_mem_byteenable;
        w_mem_writedata  = r_mem_writedata;
        w_mem_chipselect = r_mem_chipselect;
        w_mem_write      = 1'b0;
        w_lane           = r_lane;
        w_cpu_rdata      = r_cpu_rdata;
        w_cpu_rvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mem_address    = cpu_addr[ADDR_W-1:2];
                    w_mem_byteenable = lane_onehot(cpu_addr[1:0]);
                    w_mem_writedata  = w_wr_word;
                    w_lane           = cpu_addr[1:0];
                    w_mem_chipselect = 1'b1;
                    w_mem_write      = cpu_we;
                    w_state_next     = cpu_we ? WR : RD_ADDR;
                end
            end
            WR: begin
                w_mem_chipselect = 1'b0;
                w_state_next     = IDLE;
            end
            RD_ADDR: begin
                // RAM has captured the address at this edge; data arrives next cycle.
                w_mem_chipselect = 1'b0;
                w_state_next     = RD_DATA;
            end
            RD_DATA: begin
                w_cpu_rdata  = w_rd_byte;
                w_cpu_rvalid = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        w_cpu_ready = (w_state_next == IDLE) && !r_mem_reset_req;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem_reset_req  <= 1'b1;
            r_mem_clken      <= 1'b0;
            r_cpu_ready      <= 1'b0;
            r_cpu_rvalid     <= 1'b0;
            r_cpu_rdata      <= '0;
            r_mem_address    <= '0;
            r_mem_byteenable <= '0;
            r_mem_chipselect <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= '0;
            r_lane           <= '0;
        end else begin
            r_mem_reset_req  <= 1'b0;
            r_mem_clken      <= 1'b1;
            r_cpu_ready      <= w_cpu_ready;
            r_cpu_rvalid     <= w_cpu_rvalid;
            r_cpu_rdata      <= w_cpu_rdata;
            r_mem_address    <= w_mem_address;
            r_mem_byteenable <= w_mem_byteenable;
            r_mem_chipselect <= w_mem_chipselect;
            r_mem_write      <= w_mem_write;
            r_mem_writedata  <= w_mem_writedata;
            r_lane           <= w_lane;
        end
    end

    assign cpu_ready      = r_cpu_ready;
    assign cpu_rvalid     = r_cpu_rvalid;
    assign cpu_rdata      = r_cpu_rdata;
    assign mem_address    = r_mem_address;
    assign mem_byteenable = r_mem_byteenable;
    assign mem_chipselect = r_mem_chipselect;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;
    assign mem_clken      = r_mem_clken;
    assign mem_reset_req  = r_mem_reset_req;

`ifdef PLS_BRIDGE_STATS_EN
    logic [15:0] r_rd_count, r_wr_count;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (r_cpu_rvalid && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if ((r_state == WR) && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign stat_rd_count = r_rd_count;
    assign stat_wr_count = r_wr_count;
`else
    assign stat_rd_count = '0;
    assign stat_wr_count = '0;
`endif

endmodule
